memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares one external memory port between the two cache instances.
- Each cache emits 25-bit memory requests with a one-cycle ready strobe. The arbiter buffers them, grants round-robin, and issues one transaction at a time.
- Read responses (16-bit) are routed back to the cache that owns the transaction.
- Sits between cache_0/cache_1 memory_request outputs and the physical memory. The cache_coherenter continues to snoop the cache-side request buses unchanged.

Parameters:
- REQ_WIDTH, 25, request word width: bit 24 = write flag, bits 23:8 = address, bits 7:0 = write data.
- RESP_WIDTH, 16, memory response width.
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before a read is abandoned. Must be ≥2.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- memory_request_0  in  25  request word from cache_0
- memory_request_ready_0  in  1  one-cycle strobe: memory_request_0 valid
- memory_request_1  in  25  request word from cache_1
- memory_request_ready_1  in  1  one-cycle strobe: memory_request_1 valid
- mem_request  out  25  request word to memory
- mem_request_valid  out  1  one-cycle strobe: mem_request valid
- mem_response  in  16  read data from memory
- mem_response_valid  in  1  one-cycle strobe: mem_response valid
- memory_response_0  out  16  read data to cache_0
- memory_response_ready_0  out  1  one-cycle strobe to cache_0
- memory_response_1  out  16  read data to cache_1
- memory_response_ready_1  out  1  one-cycle strobe to cache_1
- timeout_error  out  1  one-cycle pulse when a read is abandoned
- overflow_error  out  1  sticky flag: a request was dropped; cleared only by reset

Behaviour:
- Reset, synchronous and active-high:
  - all outputs 0; state IDLE; both pending bits 0; timeout counter 0.
  - last_grant = 1, so channel 0 wins the first tie.
  - Reset mid-transaction abandons it silently. A later mem_response_valid is ignored.
- Capture, per channel i:
  - memory_request_ready_i high with pending_i = 0: the buffer loads memory_request_i and pending_i sets at that edge.
  - Strobe with pending_i = 1: the request is dropped, the buffer is unchanged, and overflow_error sets.
- State IDLE:
  - No pending requests: stay in IDLE.
  - Exactly one pending: grant it.
  - Both pending: grant the channel != last_grant.
  - On a grant, at the same edge: the buffer copies to the issue register, pending_g clears, last_grant = g, and the state moves to ISSUE.
  - A strobe on channel g in that same cycle sees pending_g = 1, so it counts as an overflow.
- State ISSUE, exactly one cycle:
  - mem_request = issue register; mem_request_valid = 1.
  - Write flag set: the write is posted with no response; next state IDLE.
  - Otherwise: next state WAIT; counter cleared.
- State WAIT:
  - mem_response_valid = 1: the next cycle drives memory_response_g = mem_response and memory_response_ready_g = 1 for one cycle; state returns to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 with no response, timeout_error pulses the next cycle and the state returns to IDLE with no response to the cache.
- Latency:
  - Strobe at cycle t gives mem_request_valid at t+2 when IDLE and uncontested.
  - Memory response at cycle r gives the cache response strobe at r+1.
  - Minimum spacing between issues is 2 cycles for writes and 3 for reads.
- Response routing:
  - Non-granted response port holds data 0 and ready 0.
  - Response data is registered and returns to 0 after the strobe.
- mem_response_valid in any state other than WAIT is ignored.
- A new capture on the non-granted channel proceeds during ISSUE and WAIT.
- mem_request holds 0 whenever mem_request_valid = 0.

Decomposition:
- Shared package memory_arbiter_pkg:
  - state encoding IDLE/ISSUE/WAIT
  - field constants WRITE_BIT = 24, ADDR_HI = 23, ADDR_LO = 8, DATA_HI = 7, DATA_LO = 0
  - channel index type (1 bit)
- One natural sub-module: request_buffer. It holds a single-entry holding register plus the pending bit, with inputs for load strobe and take. It is instantiated twice.

Test Plan:
- Single read: ch0 strobe with 0x0_1234_00 at t=5 -> mem_request_valid at t=7 with 0x0123400. Memory response 0xBEEF at t=10 -> memory_response_0 = 0xBEEF with ready_0 at t=11; ch1 outputs stay 0.
- Tie: both channels strobe the same cycle, ch0 addr 0x0001 and ch1 addr 0x0002, both reads, memory answers after 3 cycles -> issue order ch0 then ch1. Repeat the tie -> ch0 granted first again, since last_grant = 1 after the ch1 grant.
- Posted write: ch1 write 0x1_00AA_55 -> one issue with the write bit set; no cache response. A following ch0 read is issued 2 cycles after the write issue.
- Overflow: ch0 strobes twice while its first request is pending behind an in-flight ch1 read -> second request dropped and overflow_error = 1 until reset; the first request is issued intact.
- Timeout: read issued and memory never responds -> timeout_error pulses exactly once, TIMEOUT_CYCLES cycles after the WAIT entry; arbiter back in IDLE. A late response 5 cycles later produces no cache strobe.
- Reset in WAIT: assert reset for 1 cycle mid-read -> all outputs 0 next cycle; a subsequent mem_response_valid is ignored; a new ch1 request is served normally.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and request-word field positions for the two-cache memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int WRITE_BIT = 24;
  localparam int ADDR_HI   = 23;
  localparam int ADDR_LO   = 8;
  localparam int DATA_HI   = 7;
  localparam int DATA_LO   = 0;

  typedef logic channel_t;

endpackage

// File: rtl/memory_arbiter_request_buffer.sv
// Single-entry holding register for one cache's memory requests.
// A strobe that arrives while an entry is already held is dropped and reported.
module memory_arbiter_request_buffer
  import memory_arbiter_pkg::*;
#(
  parameter int WIDTH = 25
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data,
  output logic             pending,
  output logic             overflow
);

  assign overflow = load && pending;

  // take only happens while pending is set, so it never collides with a load
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
      data    <= '0;
    end else begin
      if (take) begin
        pending <= 1'b0;
      end
      if (load && !pending) begin
        pending <= 1'b1;
        data    <= data_in;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between two caches.
// Requests are buffered per cache, issued one at a time, and read data returns to the owner.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int REQ_WIDTH      = 25,
  parameter int RESP_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REQ_WIDTH-1:0]  memory_request_0,
  input  logic                  memory_request_ready_0,
  input  logic [REQ_WIDTH-1:0]  memory_request_1,
  input  logic                  memory_request_ready_1,
  output logic [REQ_WIDTH-1:0]  mem_request,
  output logic                  mem_request_valid,
  input  logic [RESP_WIDTH-1:0] mem_response,
  input  logic                  mem_response_valid,
  output logic [RESP_WIDTH-1:0] memory_response_0,
  output logic                  memory_response_ready_0,
  output logic [RESP_WIDTH-1:0] memory_response_1,
  output logic                  memory_response_ready_1,
  output logic                  timeout_error,
  output logic                  overflow_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  state_t               state, next_state;
  channel_t             last_grant, owner, grant_ch;
  logic                 grant_valid, resp_hit, timed_out;
  logic                 take_0, take_1;
  logic                 pending_0, pending_1;
  logic                 overflow_0, overflow_1;
  logic [REQ_WIDTH-1:0] buffer_0, buffer_1, issue_req;
  logic [CNT_W-1:0]     wait_count;

  memory_arbiter_request_buffer #(.WIDTH(REQ_WIDTH)) u_buffer_0 (
    .clock    (clock),
    .reset    (reset),
    .load     (memory_request_ready_0),
    .take     (take_0),
    .data_in  (memory_request_0),
    .data     (buffer_0),
    .pending  (pending_0),
    .overflow (overflow_0)
  );

  memory_arbiter_request_buffer #(.WIDTH(REQ_WIDTH)) u_buffer_1 (
    .clock    (clock),
    .reset    (reset),
    .load     (memory_request_ready_1),
    .take     (take_1),
    .data_in  (memory_request_1),
    .data     (buffer_1),
    .pending  (pending_1),
    .overflow (overflow_1)
  );

  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    grant_ch    = last_grant;
    resp_hit    = 1'b0;
    timed_out   = 1'b0;
    case (state)
      IDLE: begin
        if (pending_0 && pending_1) begin
          grant_valid = 1'b1;
          grant_ch    = ~last_grant;
        end else if (pending_0 || pending_1) begin
          grant_valid = 1'b1;
          grant_ch    = pending_1;
        end
        if (grant_valid) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = issue_req[WRITE_BIT] ? IDLE : WAIT;
      end
      WAIT: begin
        if (mem_response_valid) begin
          resp_hit   = 1'b1;
          next_state = IDLE;
        end else if (wait_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timed_out  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign take_0            = grant_valid && (grant_ch == 1'b0);
  assign take_1            = grant_valid && (grant_ch == 1'b1);
  assign mem_request_valid = (state == ISSUE);
  assign mem_request       = mem_request_valid ? issue_req : '0;

  // Response ports and timeout are one-cycle pulses, so they default back to 0 every edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= IDLE;
      last_grant              <= 1'b1;
      owner                   <= 1'b0;
      issue_req               <= '0;
      wait_count              <= '0;
      memory_response_0       <= '0;
      memory_response_ready_0 <= 1'b0;
      memory_response_1       <= '0;
      memory_response_ready_1 <= 1'b0;
      timeout_error           <= 1'b0;
      overflow_error          <= 1'b0;
    end else begin
      state                   <= next_state;
      memory_response_0       <= '0;
      memory_response_ready_0 <= 1'b0;
      memory_response_1       <= '0;
      memory_response_ready_1 <= 1'b0;
      timeout_error           <= timed_out;
      if (grant_valid) begin
        issue_req  <= grant_ch ? buffer_1 : buffer_0;
        last_grant <= grant_ch;
        owner      <= grant_ch;
      end
      if (state == ISSUE) begin
        wait_count <= '0;
      end else if (state == WAIT && !resp_hit && !timed_out) begin
        wait_count <= wait_count + CNT_W'(1);
      end
      if (resp_hit) begin
        if (owner == 1'b0) begin
          memory_response_0       <= mem_response;
          memory_response_ready_0 <= 1'b1;
        end else begin
          memory_response_1       <= mem_response;
          memory_response_ready_1 <= 1'b1;
        end
      end
      if (overflow_0 || overflow_1) begin
        overflow_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, corner-case sequences,
// and randomized traffic compared each cycle against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [24:0] memory_request_0, memory_request_1, mem_request;
  logic        memory_request_ready_0, memory_request_ready_1, mem_request_valid;
  logic [15:0] mem_response, memory_response_0, memory_response_1;
  logic        mem_response_valid, memory_response_ready_0, memory_response_ready_1;
  logic        timeout_error, overflow_error;
  logic [61:0] dut_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic        rdy0;
    logic [24:0] req0;
    logic        rdy1;
    logic [24:0] req1;
    logic        mv;
    logic [15:0] md;
    logic [61:0] exp;
  } vec_t;

  vec_t table_v[22];

  // Reference model: an in-flight transaction is tracked by its age since the grant
  logic [1:0]  m_pend;
  logic [24:0] m_buf[2];
  int          m_last, m_owner, m_age;
  logic        m_busy;
  logic [24:0] m_req;
  logic [15:0] m_r0, m_r1;
  logic        m_k0, m_k1, m_tmo, m_ovf;

  always #5 clock = ~clock;

  memory_arbiter #(.REQ_WIDTH(25), .RESP_WIDTH(16), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .memory_request_0        (memory_request_0),
    .memory_request_ready_0  (memory_request_ready_0),
    .memory_request_1        (memory_request_1),
    .memory_request_ready_1  (memory_request_ready_1),
    .mem_request             (mem_request),
    .mem_request_valid       (mem_request_valid),
    .mem_response            (mem_response),
    .mem_response_valid      (mem_response_valid),
    .memory_response_0       (memory_response_0),
    .memory_response_ready_0 (memory_response_ready_0),
    .memory_response_1       (memory_response_1),
    .memory_response_ready_1 (memory_response_ready_1),
    .timeout_error           (timeout_error),
    .overflow_error          (overflow_error)
  );

  function automatic logic [61:0] pack_out(logic [24:0] mreq, logic mval, logic [15:0] r0,
                                           logic k0, logic [15:0] r1, logic k1,
                                           logic tmo, logic ovf);
    return {mreq, mval, r0, k0, r1, k1, tmo, ovf};
  endfunction

  assign dut_out = pack_out(mem_request, mem_request_valid, memory_response_0,
                            memory_response_ready_0, memory_response_1,
                            memory_response_ready_1, timeout_error, overflow_error);

  function automatic vec_t mk(logic rst, logic rdy0, logic [24:0] req0, logic rdy1,
                              logic [24:0] req1, logic mv, logic [15:0] md, logic [61:0] exp);
    vec_t v;
    v.rst = rst; v.rdy0 = rdy0; v.req0 = req0; v.rdy1 = rdy1; v.req1 = req1;
    v.mv = mv; v.md = md; v.exp = exp;
    return v;
  endfunction

  function automatic logic [61:0] model_out();
    logic issuing;
    issuing = m_busy && (m_age == 1);
    return pack_out(issuing ? m_req : 25'd0, issuing, m_r0, m_k0, m_r1, m_k1, m_tmo, m_ovf);
  endfunction

  task automatic modelEdge(input vec_t v);
    logic [1:0] old_pend;
    logic [1:0] strobe;
    logic       was_busy;
    int         g;
    if (v.rst) begin
      m_pend = 2'b00; m_busy = 1'b0; m_last = 1; m_owner = 0; m_age = 0; m_req = '0;
      m_r0 = '0; m_k0 = 1'b0; m_r1 = '0; m_k1 = 1'b0; m_tmo = 1'b0; m_ovf = 1'b0;
      return;
    end
    old_pend = m_pend;
    was_busy = m_busy;
    strobe   = {v.rdy1, v.rdy0};
    m_r0 = '0; m_k0 = 1'b0; m_r1 = '0; m_k1 = 1'b0; m_tmo = 1'b0;
    if (was_busy) begin
      if (m_age == 1) begin
        if (m_req[24]) m_busy = 1'b0;
        else m_age = 2;
      end else if (v.mv) begin
        if (m_owner == 0) begin m_r0 = v.md; m_k0 = 1'b1; end
        else begin m_r1 = v.md; m_k1 = 1'b1; end
        m_busy = 1'b0;
      end else if (m_age == TIMEOUT + 1) begin
        m_tmo  = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end else if (old_pend != 2'b00) begin
      if (old_pend == 2'b11) g = (m_last == 1) ? 0 : 1;
      else g = old_pend[1] ? 1 : 0;
      m_busy = 1'b1; m_age = 1; m_owner = g; m_last = g; m_req = m_buf[g];
      m_pend[g] = 1'b0;
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (strobe[ch]) begin
        if (old_pend[ch]) m_ovf = 1'b1;
        else begin
          m_pend[ch] = 1'b1;
          m_buf[ch]  = (ch == 1) ? v.req1 : v.req0;
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [61:0] act, input logic [61:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit use_table, input string tag);
    reset = v.rst;
    memory_request_ready_0 = v.rdy0; memory_request_0 = v.req0;
    memory_request_ready_1 = v.rdy1; memory_request_1 = v.req1;
    mem_response_valid = v.mv; mem_response = v.md;
    checkOutput({"model_", tag}, dut_out, model_out());
    if (use_table) checkOutput({"table_", tag}, dut_out, v.exp);
    @(posedge clock);
    modelEdge(v);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, "idle");
  endtask

  task automatic runUntilIssue(input int limit, input logic [24:0] exp_req, input string name);
    logic        found;
    logic [24:0] got;
    found = 1'b0;
    got   = '0;
    for (int i = 0; i < limit; i++) begin
      if (mem_request_valid === 1'b1) begin
        found = 1'b1;
        got   = mem_request;
        break;
      end
      idleCycle();
    end
    checkOutput(name, {36'd0, found, got}, {36'd0, 1'b1, exp_req});
  endtask

  task automatic serveRead(input int delay, input int ch, input logic [15:0] data, input string name);
    for (int i = 0; i < delay; i++) idleCycle();
    applyStimulus(mk(0, 0, 0, 0, 0, 1, data, 0), 0, "resp");
    if (ch == 0) checkOutput(name, {28'd0, memory_response_ready_0, memory_response_0,
                                    memory_response_ready_1, memory_response_1},
                             {28'd0, 1'b1, data, 1'b0, 16'd0});
    else checkOutput(name, {28'd0, memory_response_ready_0, memory_response_0,
                            memory_response_ready_1, memory_response_1},
                     {28'd0, 1'b0, 16'd0, 1'b1, data});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rst_v;
    vec_t v;
    int   pulses, seen_at;

    for (int i = 0; i < 22; i++) table_v[i] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    table_v[5]  = mk(0, 1, 25'h0123400, 0, 0, 0, 0, 0);
    table_v[7]  = mk(0, 0, 0, 0, 0, 0, 0, pack_out(25'h0123400, 1, 0, 0, 0, 0, 0, 0));
    table_v[10] = mk(0, 0, 0, 0, 0, 1, 16'hBEEF, 0);
    table_v[11] = mk(0, 0, 0, 0, 0, 0, 0, pack_out(0, 0, 16'hBEEF, 1, 0, 0, 0, 0));
    table_v[13] = mk(0, 0, 0, 1, 25'h100AA55, 0, 0, 0);
    table_v[14] = mk(0, 1, 25'h0000100, 0, 0, 0, 0, 0);
    table_v[15] = mk(0, 0, 0, 0, 0, 0, 0, pack_out(25'h100AA55, 1, 0, 0, 0, 0, 0, 0));
    table_v[17] = mk(0, 0, 0, 0, 0, 0, 0, pack_out(25'h0000100, 1, 0, 0, 0, 0, 0, 0));
    table_v[19] = mk(0, 0, 0, 0, 0, 1, 16'h1111, 0);
    table_v[20] = mk(0, 0, 0, 0, 0, 0, 0, pack_out(0, 0, 16'h1111, 1, 0, 0, 0, 0));

    rst_v = mk(1, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    memory_request_ready_0 = 1'b0; memory_request_0 = '0;
    memory_request_ready_1 = 1'b0; memory_request_1 = '0;
    mem_response_valid = 1'b0; mem_response = '0;
    repeat (2) begin
      @(posedge clock);
      modelEdge(rst_v);
    end
    #1;

    // Directed table: single read, then posted write followed by a read
    for (int i = 0; i < 22; i++) applyStimulus(table_v[i], 1, $sformatf("row%0d", i));

    // Tie between channels, twice, from a fresh reset
    applyStimulus(rst_v, 0, "rst");
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(mk(0, 1, 25'h0000100, 1, 25'h0000200, 0, 0, 0), 0, "tie");
      runUntilIssue(10, 25'h0000100, $sformatf("tie%0d_first_ch0", rep));
      serveRead(3, 0, 16'hA001, $sformatf("tie%0d_resp_ch0", rep));
      runUntilIssue(10, 25'h0000200, $sformatf("tie%0d_second_ch1", rep));
      serveRead(3, 1, 16'hA002, $sformatf("tie%0d_resp_ch1", rep));
    end

    // Overflow behind an in-flight ch1 read
    applyStimulus(rst_v, 0, "rst");
    applyStimulus(mk(0, 0, 0, 1, 25'h0000300, 0, 0, 0), 0, "ovf");
    runUntilIssue(10, 25'h0000300, "ovf_ch1_issue");
    applyStimulus(mk(0, 1, 25'h0000400, 0, 0, 0, 0, 0), 0, "ovf_a");
    applyStimulus(mk(0, 1, 25'h0000500, 0, 0, 0, 0, 0), 0, "ovf_b");
    checkOutput("ovf_set", {61'd0, overflow_error}, 62'd1);
    serveRead(0, 1, 16'hC003, "ovf_resp_ch1");
    runUntilIssue(10, 25'h0000400, "ovf_first_intact");
    serveRead(2, 0, 16'hC004, "ovf_resp_ch0");
    checkOutput("ovf_sticky", {61'd0, overflow_error}, 62'd1);
    applyStimulus(rst_v, 0, "rst");
    checkOutput("ovf_cleared", {61'd0, overflow_error}, 62'd0);

    // Timeout, then a late response that must be ignored
    applyStimulus(mk(0, 1, 25'h0000600, 0, 0, 0, 0, 0), 0, "tmo");
    runUntilIssue(10, 25'h0000600, "tmo_issue");
    pulses  = 0;
    seen_at = -1;
    for (int i = 1; i <= TIMEOUT + 5; i++) begin
      idleCycle();
      if (timeout_error === 1'b1) begin
        pulses++;
        if (seen_at < 0) seen_at = i;
      end
    end
    checkOutput("tmo_cycle", 62'(seen_at), 62'(TIMEOUT + 1));
    checkOutput("tmo_once", 62'(pulses), 62'd1);
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 16'h7777, 0), 0, "late");
    checkOutput("late_resp_ignored", {60'd0, memory_response_ready_0, memory_response_ready_1}, 62'd0);

    // Reset while waiting for read data
    applyStimulus(mk(0, 1, 25'h0000800, 0, 0, 0, 0, 0), 0, "rw");
    runUntilIssue(10, 25'h0000800, "rw_issue");
    idleCycle();
    applyStimulus(rst_v, 0, "rw_rst");
    checkOutput("rw_outputs_zero", dut_out, 62'd0);
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 16'hDEAD, 0), 0, "rw_stale");
    checkOutput("rw_stale_ignored", {60'd0, memory_response_ready_0, memory_response_ready_1}, 62'd0);
    applyStimulus(mk(0, 0, 0, 1, 25'h0000900, 0, 0, 0), 0, "rw_new");
    runUntilIssue(10, 25'h0000900, "rw_new_issue");
    serveRead(2, 1, 16'h5A5A, "rw_new_resp");

    // Randomized traffic against the model, with quiet windows to provoke timeouts
    for (int i = 0; i < 4000; i++) begin
      v.rst  = ($urandom_range(0, 599) == 0);
      v.rdy0 = ($urandom_range(0, 4) == 0);
      v.req0 = 25'($urandom);
      v.rdy1 = ($urandom_range(0, 4) == 0);
      v.req1 = 25'($urandom);
      v.mv   = ((i % 700) >= 600) ? 1'b0 : ($urandom_range(0, 3) == 0);
      v.md   = 16'($urandom);
      v.exp  = '0;
      applyStimulus(v, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
